// File: rtl/cu_pipe_decode_if.sv
// cu_pipe_decode_if
// Groups the decode stage's handshake and control bus into one bundle.
// The IF/ID side, hazard unit, branch logic and debug unit drive the I_CU_*
// signals. The decode stage drives the registered ID/EX control bundle on
// the O_CU_* signals.
//
// Modports:
//   master - the environment around the decoder: drives I_CU_*, reads O_CU_*
//   slave  - the decoder itself: reads I_CU_*, drives O_CU_*
//
// Signals:
//   I_CU_VALID / I_CU_OP / I_CU_FUNCT / I_CU_RS / I_CU_RT / I_CU_RD
//       instruction fields arriving from IF/ID
//   I_CU_STALL / I_CU_FLUSH / I_CU_RESUME
//       hazard, branch and debug controls
//   O_CU_*
//       registered control bundle, PC freeze, halt status and instruction count
interface cu_pipe_decode_if #(
    parameter int OP_W   = 6,
    parameter int ALUC_W = 6,
    parameter int CNT_W  = 16
);
    logic              I_CU_VALID;
    logic [OP_W-1:0]   I_CU_OP;
    logic [OP_W-1:0]   I_CU_FUNCT;
    logic [4:0]        I_CU_RS;
    logic [4:0]        I_CU_RT;
    logic [4:0]        I_CU_RD;
    logic              I_CU_STALL;
    logic              I_CU_FLUSH;
    logic              I_CU_RESUME;

    logic              O_CU_VALID;
    logic              O_CU_MemtoReg;
    logic              O_CU_RegWrite;
    logic              O_CU_MemWrite;
    logic              O_CU_MemRead;
    logic              O_CU_BranchEQ;
    logic              O_CU_BranchNE;
    logic              O_CU_ALUSrc;
    logic              O_CU_RegDst;
    logic              O_CU_signed;
    logic              O_CU_shift;
    logic              O_CU_Jump;
    logic              O_CU_LinkR;
    logic              O_CU_R;
    logic [ALUC_W-1:0] O_CU_ALUControl;
    logic [1:0]        O_CU_Trunk;
    logic [4:0]        O_CU_DST;
    logic              O_CU_STALL_PC;
    logic              O_CU_HALTED;
    logic [CNT_W-1:0]  O_CU_INSTR_CNT;

    modport master (
        output I_CU_VALID, I_CU_OP, I_CU_FUNCT, I_CU_RS, I_CU_RT, I_CU_RD,
               I_CU_STALL, I_CU_FLUSH, I_CU_RESUME,
        input  O_CU_VALID, O_CU_MemtoReg, O_CU_RegWrite, O_CU_MemWrite,
               O_CU_MemRead, O_CU_BranchEQ, O_CU_BranchNE, O_CU_ALUSrc,
               O_CU_RegDst, O_CU_signed, O_CU_shift, O_CU_Jump, O_CU_LinkR,
               O_CU_R, O_CU_ALUControl, O_CU_Trunk, O_CU_DST,
               O_CU_STALL_PC, O_CU_HALTED, O_CU_INSTR_CNT
    );

    modport slave (
        input  I_CU_VALID, I_CU_OP, I_CU_FUNCT, I_CU_RS, I_CU_RT, I_CU_RD,
               I_CU_STALL, I_CU_FLUSH, I_CU_RESUME,
        output O_CU_VALID, O_CU_MemtoReg, O_CU_RegWrite, O_CU_MemWrite,
               O_CU_MemRead, O_CU_BranchEQ, O_CU_BranchNE, O_CU_ALUSrc,
               O_CU_RegDst, O_CU_signed, O_CU_shift, O_CU_Jump, O_CU_LinkR,
               O_CU_R, O_CU_ALUControl, O_CU_Trunk, O_CU_DST,
               O_CU_STALL_PC, O_CU_HALTED, O_CU_INSTR_CNT
    );
endinterface

// File: rtl/cu_pipe_decode.sv
// cu_pipe_decode
// Pipelined MIPS control decode. It decodes opcode/funct in ID and registers
// the full control bundle into the ID/EX boundary. It also provides:
//   - valid/stall/flush handling
//   - a HALT drain-and-stop FSM (RUN -> DRAIN -> HALTED -> RUN on resume)
//   - a counter of valid instructions loaded into ID/EX
//
// Ports:
//   I_CLK - clock
//   I_RST - synchronous active-high reset
//   bus   - cu_pipe_decode_if.slave
//             inputs:  instruction fields, stall/flush/resume
//             outputs: registered bundle, O_CU_STALL_PC (combinational),
//                      O_CU_HALTED, O_CU_INSTR_CNT
//
// Optional feature:
//   CU_LOADUSE_EN - when defined, adds internal load-use hazard detection
//                   against the instruction currently held in ID/EX.
module cu_pipe_decode #(
    parameter int OP_W         = 6,
    parameter int ALUC_W       = 6,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input logic             I_CLK,
    input logic             I_RST,
    cu_pipe_decode_if.slave bus
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_LBU   = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] OP_LH    = OP_W'(6'b100001);
    localparam logic [OP_W-1:0] OP_LHU   = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_LWU   = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(6'b101000);
    localparam logic [OP_W-1:0] OP_SH    = OP_W'(6'b101001);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(6'b111110);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b010101);

    localparam logic [OP_W-1:0] FN_SLL   = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] FN_SRL   = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] FN_SRA   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] FN_JR    = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] FN_JALR  = OP_W'(6'b001001);

    localparam logic [ALUC_W-1:0] ALU_ADD  = ALUC_W'(6'b100001);
    localparam logic [ALUC_W-1:0] ALU_AND  = ALUC_W'(6'b100100);
    localparam logic [ALUC_W-1:0] ALU_OR   = ALUC_W'(6'b100101);
    localparam logic [ALUC_W-1:0] ALU_XOR  = ALUC_W'(6'b100110);
    localparam logic [ALUC_W-1:0] ALU_SLT  = ALUC_W'(6'b101010);
    localparam logic [ALUC_W-1:0] ALU_NOP  = ALUC_W'(6'b111110);

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              branch_eq;
        logic              branch_ne;
        logic              alu_src;
        logic              reg_dst;
        logic              sgn;
        logic              shift;
        logic              jump;
        logic              link_r;
        logic              r;
        logic [ALUC_W-1:0] alu_ctl;
        logic [1:0]        trunk;
    } ctl_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    ctl_t           dec;
    logic [4:0]     dec_dst;
    ctl_t           ctl_q;
    logic           valid_q;
    logic [4:0]     dst_q;
    logic           halted_q;
    logic [CNT_W-1:0] cnt_q;
    state_t         state;
    logic [DCW-1:0] drain_cnt;
    logic           load_use;
    logic           halt_accept;

    // Pure opcode/funct decode; anything not recognised falls out as all-zero.
    always_comb begin
        dec = '0;
        case (bus.I_CU_OP)
            OP_RTYPE: begin
                if (bus.I_CU_FUNCT == FN_JR) begin
                    dec.jump = 1'b1;
                    dec.r    = 1'b1;
                end else if (bus.I_CU_FUNCT == FN_JALR) begin
                    dec.jump       = 1'b1;
                    dec.r          = 1'b1;
                    dec.link_r     = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.shift      = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.reg_dst   = 1'b1;
                    dec.alu_ctl   = ALUC_W'(bus.I_CU_FUNCT);
                    dec.alu_src   = bus.I_CU_FUNCT inside {FN_SLL, FN_SRL, FN_SRA};
                end
            end
            OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = ALU_ADD;
                dec.sgn       = 1'b1;
            end
            OP_ANDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = ALU_AND;
            end
            OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = ALU_OR;
            end
            OP_XORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = ALU_XOR;
            end
            OP_SLTI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = ALU_SLT;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.shift     = 1'b1;
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU: begin
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_ctl    = ALU_ADD;
                dec.sgn        = bus.I_CU_OP inside {OP_LB, OP_LH, OP_LW};
                if (bus.I_CU_OP inside {OP_LB, OP_LBU}) begin
                    dec.trunk = 2'b10;
                end else if (bus.I_CU_OP inside {OP_LH, OP_LHU}) begin
                    dec.trunk = 2'b01;
                end
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = ALU_ADD;
                dec.sgn       = 1'b1;
                if (bus.I_CU_OP == OP_SB) begin
                    dec.trunk = 2'b10;
                end else if (bus.I_CU_OP == OP_SH) begin
                    dec.trunk = 2'b01;
                end
            end
            OP_BEQ: dec.branch_eq = 1'b1;
            OP_BNE: dec.branch_ne = 1'b1;
            OP_J:   dec.jump      = 1'b1;
            OP_JAL: begin
                dec.jump       = 1'b1;
                dec.link_r     = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.shift      = 1'b1;
            end
            OP_NOP:  dec.alu_ctl = ALU_NOP;
            default: dec = '0;
        endcase
    end

    // Link instructions always write $ra, regardless of RegDst.
    assign dec_dst = dec.link_r  ? 5'd31 :
                     dec.reg_dst ? bus.I_CU_RD : bus.I_CU_RT;

`ifdef CU_LOADUSE_EN
    logic reads_rt;

    // Only these classes actually source rt; I-type ALU and loads use rt as a destination.
    assign reads_rt = bus.I_CU_OP inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};

    // A flush squashes the consumer anyway, so it suppresses the hazard.
    assign load_use = valid_q && ctl_q.mem_read && (dst_q != 5'd0) && !bus.I_CU_FLUSH &&
                      ((dst_q == bus.I_CU_RS) || (reads_rt && (dst_q == bus.I_CU_RT)));
`else
    logic unused_rs;

    assign unused_rs = ^bus.I_CU_RS;
    assign load_use  = 1'b0;
`endif

    assign halt_accept = (state == ST_RUN) && bus.I_CU_VALID && (bus.I_CU_OP == OP_HALT) &&
                         !bus.I_CU_FLUSH && !bus.I_CU_STALL && !load_use;

    // The PC freezes as soon as HALT is accepted so nothing behind it enters IF/ID.
    assign bus.O_CU_STALL_PC = (state != ST_RUN) || halt_accept || bus.I_CU_STALL || load_use;

    // ID/EX register, instruction counter and HALT FSM share one update block so
    // the priority flush > stall > load-use > load is expressed in one place.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            ctl_q     <= '0;
            valid_q   <= 1'b0;
            dst_q     <= 5'd0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
            drain_cnt <= '0;
            state     <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.I_CU_FLUSH || (!bus.I_CU_STALL && (load_use || !bus.I_CU_VALID))) begin
                        ctl_q   <= '0;
                        valid_q <= 1'b0;
                        dst_q   <= 5'd0;
                    end else if (!bus.I_CU_STALL) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (bus.I_CU_OP == OP_HALT) begin
                            ctl_q     <= '0;
                            valid_q   <= 1'b0;
                            dst_q     <= 5'd0;
                            drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                            state     <= ST_DRAIN;
                        end else begin
                            ctl_q   <= dec;
                            valid_q <= 1'b1;
                            dst_q   <= dec_dst;
                        end
                    end
                end
                ST_DRAIN: begin
                    ctl_q   <= '0;
                    valid_q <= 1'b0;
                    dst_q   <= 5'd0;
                    if (drain_cnt == '0) begin
                        halted_q <= 1'b1;
                        state    <= ST_HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    ctl_q   <= '0;
                    valid_q <= 1'b0;
                    dst_q   <= 5'd0;
                    if (bus.I_CU_RESUME) begin
                        halted_q <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.O_CU_VALID      = valid_q;
    assign bus.O_CU_MemtoReg   = ctl_q.mem_to_reg;
    assign bus.O_CU_RegWrite   = ctl_q.reg_write;
    assign bus.O_CU_MemWrite   = ctl_q.mem_write;
    assign bus.O_CU_MemRead    = ctl_q.mem_read;
    assign bus.O_CU_BranchEQ   = ctl_q.branch_eq;
    assign bus.O_CU_BranchNE   = ctl_q.branch_ne;
    assign bus.O_CU_ALUSrc     = ctl_q.alu_src;
    assign bus.O_CU_RegDst     = ctl_q.reg_dst;
    assign bus.O_CU_signed     = ctl_q.sgn;
    assign bus.O_CU_shift      = ctl_q.shift;
    assign bus.O_CU_Jump       = ctl_q.jump;
    assign bus.O_CU_LinkR      = ctl_q.link_r;
    assign bus.O_CU_R          = ctl_q.r;
    assign bus.O_CU_ALUControl = ctl_q.alu_ctl;
    assign bus.O_CU_Trunk      = ctl_q.trunk;
    assign bus.O_CU_DST        = dst_q;
    assign bus.O_CU_HALTED     = halted_q;
    assign bus.O_CU_INSTR_CNT  = cnt_q;

endmodule

// File: doc/cu_pipe_decode.md
Name: cu_pipe_decode

Overview:
Registered, pipelined successor of the single-cycle MIPS control decode. Decodes opcode/funct in the ID stage and registers the full control bundle into the ID/EX boundary, with valid/stall/flush handling, a HALT drain-and-stop FSM, a debug resume, and a decoded-instruction counter. It sits between the IF/ID register and the EX stage. Hazard unit, branch logic and debug unit drive its stall, flush and resume inputs.

Parameters:
OP_W, 6, opcode and funct width
ALUC_W, 6, ALU control width
DRAIN_CYCLES, 4, bubble cycles emitted after HALT before HALTED asserts (>=1)
CNT_W, 16, width of the decoded-instruction counter

Ports:
I_CLK  in  1  clock
I_RST  in  1  synchronous active-high reset
I_CU_VALID  in  1  IF/ID holds a valid instruction
I_CU_OP  in  OP_W  opcode
I_CU_FUNCT  in  OP_W  funct
I_CU_RS, I_CU_RT, I_CU_RD  in  5 each  register fields
I_CU_STALL  in  1  hold ID/EX register
I_CU_FLUSH  in  1  squash instruction being decoded
I_CU_RESUME  in  1  leave HALTED
O_CU_VALID  out  1  registered bundle is a real instruction
O_CU_MemtoReg, O_CU_RegWrite, O_CU_MemWrite, O_CU_MemRead, O_CU_BranchEQ, O_CU_BranchNE, O_CU_ALUSrc, O_CU_RegDst, O_CU_signed, O_CU_shift, O_CU_Jump, O_CU_LinkR, O_CU_R  out  1 each  registered control
O_CU_ALUControl  out  ALUC_W  registered ALU op
O_CU_Trunk  out  2  00 word, 01 half, 10 byte
O_CU_DST  out  5  write register: 31 if LinkR, else rd if RegDst, else rt
O_CU_STALL_PC  out  1  freeze PC and IF/ID (combinational)
O_CU_HALTED  out  1  core stopped
O_CU_INSTR_CNT  out  CNT_W  count of valid instructions loaded

Behaviour:
- Clock and reset: one clock, I_CLK; reset is synchronous and active-high, I_RST.
- Reset: all outputs 0, FSM=RUN, counter 0.
- Decode fields not listed are 0.
  - R-type (op 000000): RegWrite, RegDst, ALUCtl=funct.
  - R-type funct 000000/000010/000011 also set ALUSrc.
  - R-type funct 001000 (JR): Jump, R only.
  - R-type funct 001001 (JALR): Jump, R, LinkR, MemtoReg, RegWrite, shift.
- Decode, I-type ALU (each sets RegWrite, ALUSrc):
  - ADDI 001000: ALUCtl 100001, signed.
  - ANDI 001100: ALUCtl 100100.
  - ORI 001101: ALUCtl 100101.
  - XORI 001110: ALUCtl 100110.
  - SLTI 001010: ALUCtl 101010.
  - LUI 001111: shift, ALUCtl 0.
- Decode, loads (each sets MemtoReg, RegWrite, MemRead, ALUSrc, ALUCtl 100001):
  - LB 100000: Trunk 10, signed.
  - LBU 100100: Trunk 10.
  - LH 100001: Trunk 01, signed.
  - LHU 100101: Trunk 01.
  - LW 100011: Trunk 00, signed.
  - LWU 100111: Trunk 00.
- Decode, stores (each sets MemWrite, ALUSrc, ALUCtl 100001, signed):
  - SB 101000: Trunk 10.
  - SH 101001: Trunk 01.
  - SW 101011: Trunk 00.
- Decode, control flow:
  - BEQ 000100: BranchEQ.
  - BNE 000101: BranchNE.
  - J 000010: Jump.
  - JAL 000011: Jump, LinkR, MemtoReg, RegWrite, shift.
- Decode, other:
  - NOP 111110: ALUCtl 111110, all else 0.
  - HALT 010101 and unknown opcodes: all 0.
- Bubble = all control outputs 0, O_CU_VALID=0, O_CU_DST=0.
- Register update priority, each edge, FSM=RUN:
  1. I_CU_FLUSH: bubble; flush beats stall.
  2. I_CU_STALL: hold all outputs.
  3. Otherwise: load the decoded bundle with VALID=I_CU_VALID. If I_CU_VALID=0, load a bubble.
- Latency: decode of a cycle-N input is visible after edge N, one cycle.
- Counter: increments on each edge that loads VALID=1 (HALT included). Wraps at 2^CNT_W to 0.
- FSM states:
  - RUN: a HALT loaded with VALID=1 and no flush/stall loads a bubble (not the HALT bundle), counts, and moves to DRAIN with drain counter=DRAIN_CYCLES-1.
  - DRAIN: outputs a bubble each cycle; STALL/FLUSH ignored; O_CU_STALL_PC=1. Drain counter 0 -> HALTED.
  - HALTED: O_CU_HALTED=1, O_CU_STALL_PC=1, outputs stay bubble. I_CU_RESUME -> RUN next edge, HALTED deasserts that edge.
- O_CU_STALL_PC: 1 in DRAIN/HALTED, also when a HALT is accepted in RUN. Otherwise equals I_CU_STALL, or the load-use stall when the optional feature is compiled in.
- I_CU_RESUME outside HALTED: ignored.
- Reset mid-DRAIN/HALTED: returns to RUN, counter cleared.

Optional Feature:
Macro CU_LOADUSE_EN.
- Defined: internal load-use detection. Stall when all hold:
  - O_CU_VALID and O_CU_MemRead are 1;
  - O_CU_DST != 0;
  - O_CU_DST equals I_CU_RS, or equals I_CU_RT where the incoming instruction reads rt (R-type, BEQ, BNE, stores).
- On a load-use stall: load a bubble, do not count, assert O_CU_STALL_PC for exactly that cycle.
- I_CU_FLUSH still has priority over the load-use stall.
- Not defined: no detection; O_CU_STALL_PC follows I_CU_STALL/FSM only; the rs/rt compare logic is absent.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, CNT=0, HALTED=0.
- ADDI (op 001000, VALID=1) -> next cycle VALID=1, RegWrite=1, ALUSrc=1, signed=1, ALUControl=100001, DST=rt; CNT=1.
- LW then STALL=1 for 2 cycles, then FLUSH=1 with STALL=1 -> LW bundle held 2 cycles, then bubble; CNT=1.
- HALT with DRAIN_CYCLES=4 -> 5 bubble cycles total, STALL_PC=1 from acceptance, HALTED=1 on 5th edge; RESUME=1 -> RUN, HALTED=0 next edge.
- CNT_W=4, 17 valid instructions -> CNT wraps 15 -> 0, ends at 1.
- CU_LOADUSE_EN: LW rt=5, then ADD rs=5 -> one bubble, STALL_PC=1 for one cycle, ADD loaded next cycle. Same pair with macro undefined -> no bubble.
